otter_scoreboard: RTL and testbench

OTTER_SCOREBOARD -- requirements
Module: otter_scoreboard

---
 rtl/otter_scoreboard.sv | 136 +++++++++++++
 tb/tb_otter_scoreboard.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/otter_scoreboard.sv
// Register-hazard scoreboard for the Otter pipeline: tracks cycles until each
// destination register is written back. `OTTER_SCOREBOARD_FWD_EN enables forwarding.
module otter_scoreboard #(
    parameter int WB_LAT = 3,
    parameter int NREGS  = 32,
    parameter int AW     = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ISSUE_VALID,
    input  logic [AW-1:0] ISSUE_RD,
    input  logic          ISSUE_RD_WE,
    input  logic          ISSUE_IS_LOAD,
    input  logic [AW-1:0] RS1_ADDR,
    input  logic [AW-1:0] RS2_ADDR,
    input  logic          RS1_USED,
    input  logic          RS2_USED,
    input  logic          FLUSH,
    output logic          STALL,
    output logic [2:0]    FWD_A_SEL,
    output logic [2:0]    FWD_B_SEL,
    output logic [31:0]   STALL_CNT
);

    localparam logic [2:0] LAT = 3'(WB_LAT);

    logic [2:0]       wb_cnt_r [NREGS];
    logic [NREGS-1:0] ld_r;
    logic             issue_s;
    logic [2:0]       cnt1_s;
    logic [2:0]       cnt2_s;
    logic             ld1_s;
    logic             ld2_s;
    logic             haz1_s;
    logic             haz2_s;

`ifdef OTTER_SCOREBOARD_FWD_EN
    // Result not yet available on any bypass path: just issued, or a load still in memory.
    function automatic logic blocks(input logic used, input logic [AW-1:0] addr,
                                    input logic [2:0] cnt, input logic ld);
        return used && (addr != {AW{1'b0}}) &&
               ((cnt == LAT) || (ld && (cnt == LAT - 3'd1)));
    endfunction

    function automatic logic [2:0] fwd_sel(input logic used, input logic [AW-1:0] addr,
                                           input logic [2:0] cnt, input logic ld);
        if (used && (addr != {AW{1'b0}}) && (cnt != 3'd0) && !blocks(used, addr, cnt, ld)) begin
            return LAT - cnt;
        end else begin
            return 3'd0;
        end
    endfunction
`else
    // Without bypassing the consumer waits until the register file holds the value.
    function automatic logic blocks(input logic used, input logic [AW-1:0] addr,
                                    input logic [2:0] cnt);
        return used && (addr != {AW{1'b0}}) && (cnt != 3'd0);
    endfunction

    logic unused_ld_s;
    assign unused_ld_s = ^{ld_r, ld1_s, ld2_s};
`endif

    // Look up per-source scoreboard state; out-of-range addresses read as idle.
    always_comb begin
        cnt1_s = 3'd0;
        cnt2_s = 3'd0;
        ld1_s  = 1'b0;
        ld2_s  = 1'b0;
        if (int'(RS1_ADDR) < NREGS) begin
            cnt1_s = wb_cnt_r[RS1_ADDR];
            ld1_s  = ld_r[RS1_ADDR];
        end else begin
            cnt1_s = 3'd0;
        end
        if (int'(RS2_ADDR) < NREGS) begin
            cnt2_s = wb_cnt_r[RS2_ADDR];
            ld2_s  = ld_r[RS2_ADDR];
        end else begin
            cnt2_s = 3'd0;
        end
    end

    // Hazard detection, stall and forwarding selects.
    always_comb begin
`ifdef OTTER_SCOREBOARD_FWD_EN
        haz1_s    = blocks(RS1_USED, RS1_ADDR, cnt1_s, ld1_s);
        haz2_s    = blocks(RS2_USED, RS2_ADDR, cnt2_s, ld2_s);
        FWD_A_SEL = fwd_sel(RS1_USED, RS1_ADDR, cnt1_s, ld1_s);
        FWD_B_SEL = fwd_sel(RS2_USED, RS2_ADDR, cnt2_s, ld2_s);
`else
        haz1_s    = blocks(RS1_USED, RS1_ADDR, cnt1_s);
        haz2_s    = blocks(RS2_USED, RS2_ADDR, cnt2_s);
        FWD_A_SEL = 3'd0;
        FWD_B_SEL = 3'd0;
`endif
        STALL   = ISSUE_VALID && !FLUSH && (haz1_s || haz2_s);
        issue_s = ISSUE_VALID && !STALL && !FLUSH && ISSUE_RD_WE &&
                  (ISSUE_RD != {AW{1'b0}});
    end

    // Per-register writeback countdown; a new producer reloads the counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NREGS; r++) begin
                wb_cnt_r[r] <= 3'd0;
            end
            ld_r <= {NREGS{1'b0}};
        end else begin
            wb_cnt_r[0] <= 3'd0;
            ld_r[0]     <= 1'b0;
            for (int r = 1; r < NREGS; r++) begin
                if (issue_s && (ISSUE_RD == AW'(r))) begin
                    wb_cnt_r[r] <= LAT;
                    ld_r[r]     <= ISSUE_IS_LOAD;
                end else if (wb_cnt_r[r] != 3'd0) begin
                    wb_cnt_r[r] <= wb_cnt_r[r] - 3'd1;
                end else begin
                    wb_cnt_r[r] <= 3'd0;
                end
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CNT <= 32'd0;
        end else if (STALL && (STALL_CNT != 32'hFFFF_FFFF)) begin
            STALL_CNT <= STALL_CNT + 32'd1;
        end else begin
            STALL_CNT <= STALL_CNT;
        end
    end

endmodule

// File: tb/tb_otter_scoreboard.sv
// Table-driven self-checking bench for otter_scoreboard (WB_LAT=3); expectations
// for both the default and the forwarding build are carried in each table row.
module tb_otter_scoreboard;

`ifdef OTTER_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        issue_is_load;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic        flush;
    logic        stall;
    logic [2:0]  fwd_a_sel;
    logic [2:0]  fwd_b_sel;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    otter_scoreboard #(.WB_LAT(3), .NREGS(32), .AW(5)) dut (
        .CLK(clk), .RST(rst), .ISSUE_VALID(issue_valid), .ISSUE_RD(issue_rd),
        .ISSUE_RD_WE(issue_rd_we), .ISSUE_IS_LOAD(issue_is_load),
        .RS1_ADDR(rs1_addr), .RS2_ADDR(rs2_addr), .RS1_USED(rs1_used),
        .RS2_USED(rs2_used), .FLUSH(flush), .STALL(stall),
        .FWD_A_SEL(fwd_a_sel), .FWD_B_SEL(fwd_b_sel), .STALL_CNT(stall_cnt)
    );

    typedef struct {
        logic       v, we, ld, u1, u2, fl;
        logic [4:0] rd, rs1, rs2;
        logic       st_nf, st_fw;
        logic [2:0] a_fw, b_fw;
    } vec_t;

    typedef struct {
        logic       st;
        logic [2:0] a, b;
    } exp_t;

    vec_t tbl [28];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic v, logic [4:0] rd, logic we, logic ld,
                                logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic fl, logic st_nf, logic st_fw,
                                logic [2:0] a_fw, logic [2:0] b_fw);
        vec_t t;
        t.v = v; t.rd = rd; t.we = we; t.ld = ld; t.rs1 = rs1; t.u1 = u1;
        t.rs2 = rs2; t.u2 = u2; t.fl = fl; t.st_nf = st_nf; t.st_fw = st_fw;
        t.a_fw = a_fw; t.b_fw = b_fw;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic fl);
        issue_valid = v; issue_rd = rd; issue_rd_we = we; issue_is_load = ld;
        rs1_addr = rs1; rs1_used = u1; rs2_addr = rs2; rs2_used = u2; flush = fl;
    endtask

    initial begin
        exp_t e;
        exp_t got;
        int   exp_stalls;

        // v  rd we ld  rs1 u1 rs2 u2 fl  st_nf st_fw a_fw b_fw
        tbl[0]  = mk(1, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);  // addi x5
        tbl[1]  = mk(1, 0, 0, 0,  5, 1, 0, 0, 0,  1, 1, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0,  5, 1, 0, 0, 0,  1, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0, 0,  5, 1, 0, 0, 0,  1, 0, 2, 0);
        tbl[4]  = mk(1, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[5]  = mk(1, 7, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0);  // load x7
        tbl[6]  = mk(1, 0, 0, 0,  0, 0, 7, 1, 0,  1, 1, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0,  0, 0, 7, 1, 0,  1, 1, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0,  0, 0, 7, 1, 0,  1, 0, 0, 2);
        tbl[9]  = mk(1, 0, 0, 0,  0, 0, 7, 1, 0,  0, 0, 0, 0);
        tbl[10] = mk(1, 0, 1, 0,  0, 1, 0, 1, 0,  0, 0, 0, 0);  // x0 traffic
        tbl[11] = mk(1, 0, 1, 1,  0, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0,  0, 1, 0, 1, 0,  0, 0, 0, 0);
        tbl[13] = mk(1, 9, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);  // alu x9
        tbl[14] = mk(1, 9, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0);  // load x9 overwrites
        tbl[15] = mk(1, 0, 0, 0,  9, 1, 0, 0, 0,  1, 1, 0, 0);
        tbl[16] = mk(1, 0, 0, 0,  9, 1, 0, 0, 0,  1, 1, 0, 0);
        tbl[17] = mk(1, 0, 0, 0,  9, 1, 0, 0, 0,  1, 0, 2, 0);
        tbl[18] = mk(1, 0, 0, 0,  9, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[19] = mk(1, 6, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        tbl[20] = mk(1, 8, 1, 0,  6, 1, 0, 0, 1,  0, 0, 0, 0);  // flushed, hazard masked
        tbl[21] = mk(1, 0, 0, 0,  8, 1, 0, 0, 0,  0, 0, 0, 0);
        tbl[22] = mk(1, 0, 0, 0,  6, 0, 6, 0, 0,  0, 0, 0, 0);  // sources unused
        tbl[23] = mk(1, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0, 0);  // no valid instr
        tbl[25] = mk(0, 0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 1, 0);
        tbl[26] = mk(1, 0, 0, 0,  5, 1, 5, 1, 0,  1, 0, 2, 2);
        tbl[27] = mk(1, 0, 0, 0,  5, 1, 5, 1, 0,  0, 0, 0, 0);

        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_fwd_a", {29'd0, fwd_a_sel}, 32'd0);
        chk("rst_fwd_b", {29'd0, fwd_b_sel}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);

        exp_stalls = 0;
        for (int i = 0; i < 28; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].v, tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].rs1, tbl[i].u1,
                  tbl[i].rs2, tbl[i].u2, tbl[i].fl);
            e.st = FWD ? tbl[i].st_fw : tbl[i].st_nf;
            e.a  = FWD ? tbl[i].a_fw : 3'd0;
            e.b  = FWD ? tbl[i].b_fw : 3'd0;
            exp_stalls += int'(e.st);
            sb_q.push_back(e);
            @(negedge clk);
            got = sb_q.pop_front();
            chk($sformatf("row%0d_stall", i), {31'd0, stall}, {31'd0, got.st});
            chk($sformatf("row%0d_fwd_a", i), {29'd0, fwd_a_sel}, {29'd0, got.a});
            chk($sformatf("row%0d_fwd_b", i), {29'd0, fwd_b_sel}, {29'd0, got.b});
        end
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("table_stall_cnt", stall_cnt, 32'(exp_stalls));

        // Hazard on x5 pending, then reset with a simultaneous issue to x10.
        @(posedge clk); #1;
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_hazard", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_drop_stall", {31'd0, stall}, 32'd0);
        chk("rst_drop_fwd_a", {29'd0, fwd_a_sel}, 32'd0);
        chk("rst_drop_fwd_b", {29'd0, fwd_b_sel}, 32'd0);
        chk("rst_clr_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_cnt_stays_0", stall_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
